bit_slice_saturate: RTL and testbench
=====================================

Name:
bit_slice_saturate

Overview:
- Registered signed-narrowing stage: takes a (WIDTH+1)-bit two's-complement sample, e.g. a butterfly sum/difference, and returns a WIDTH-bit sample.
- In-range values are passed by dropping the redundant sign bit; out-of-range values clamp to the signed min/max.
- Sits at the output of each FFT butterfly adder/subtractor, before write-back to the in-place memory.
- Also flags saturation events and keeps a sticky, saturating event count for debug.

Parameters:
- WIDTH, 16, output sample width in bits; input width is WIDTH+1.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in is valid this cycle.
- data_in  input  WIDTH+1  signed two's-complement sample.
- cnt_clr  input  1  synchronous clear of sat_cnt and sat_sticky.
- out_valid  output  1  data_out is valid; registered copy of in_valid.
- data_out  output  WIDTH  signed saturated sample.
- sat_pos  output  1  the registered sample was clamped to +max.
- sat_neg  output  1  the registered sample was clamped to −min.
- sat_sticky  output  1  at least one saturation since reset/clear.
- sat_cnt  output  CNT_W  number of saturation events since reset/clear; sticks at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, data_out=0, sat_pos=0, sat_neg=0, sat_sticky=0, sat_cnt=0. These hold while rst_n is low. Normal operation starts on the first rising edge after release.
- Overflow detect is combinational: ovf = data_in[WIDTH] XOR data_in[WIDTH-1].
- Result selection:
  - ovf=0: result = data_in[WIDTH-1:0] (bit slice, value preserved).
  - ovf=1 and data_in[WIDTH]=0: result = 0 followed by WIDTH-1 ones (+2^(WIDTH-1)−1); pos=1.
  - ovf=1 and data_in[WIDTH]=1: result = 1 followed by WIDTH-1 zeros (−2^(WIDTH-1)); neg=1.
- Latency: exactly 1 clock. On each rising edge:
  - out_valid <= in_valid.
  - If in_valid=1: data_out <= result, sat_pos <= pos, sat_neg <= neg.
  - If in_valid=0: data_out holds its previous value; sat_pos and sat_neg are cleared to 0.
- No backpressure; one sample per cycle at full throughput, including back-to-back valid cycles.
- Counter and sticky flag, evaluated each edge:
  - If cnt_clr=1: sat_cnt <= 0 and sat_sticky <= 0. Clear takes priority over a simultaneous saturation event, which is not counted.
  - Else if in_valid=1 and ovf=1: sat_sticky <= 1, and sat_cnt increments unless it is already all-ones (no wrap).
- Boundary values (WIDTH=16):
  - +32767 and −32768 pass unchanged, no flag.
  - +32768 → 32767 with sat_pos.
  - −32769 → −32768 with sat_neg.
  - Input extremes +65535/−65536 clamp likewise.
- Asserting rst_n low mid-stream immediately clears all outputs. The in-flight sample is discarded.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and data_in=34468 → all outputs 0. Release, apply one valid sample → out_valid=1 one cycle later.
- In-range, back-to-back valids: −3168, −1, −2, 2, 3 → data_out 0xF3A0, 0xFFFF, 0xFFFE, 0x0002, 0x0003, each 1 cycle after its input. No sat flags.
- Positive clamp: 34468 (0x086A4) → data_out 0x7FFF, sat_pos=1. Then 32767 → 0x7FFF with sat_pos=0; 32768 → 0x7FFF with sat_pos=1.
- Negative clamp: −34468 → 0x8000, sat_neg=1. Then −32768 → 0x8000 with no flag; −32769 → 0x8000 with sat_neg=1.
- Counter: 3 saturating samples → sat_cnt=3, sat_sticky=1. cnt_clr in the same cycle as a 4th saturating sample → sat_cnt=0, sticky=0. With CNT_W=2 and 5 saturations → sat_cnt holds at 3.
- Valid gating: in_valid=0 with data_in=34468 → out_valid=0, data_out unchanged, sat_pos=0, sat_cnt unchanged.

Source files
------------

// File: rtl/bit_slice_saturate.sv
// Registered signed narrowing stage: (WIDTH+1)-bit two's-complement in, WIDTH-bit out,
// clamping out-of-range samples and keeping a sticky, saturating count of clamp events.
module bit_slice_saturate #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH:0]   data_in,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             sat_pos,
  output logic             sat_neg,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             ovf;
  logic             pos_next;
  logic             neg_next;
  logic [WIDTH-1:0] result_next;
  logic             cnt_full;

  logic             out_valid_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             sat_pos_reg;
  logic             sat_neg_reg;
  logic             sat_sticky_reg;
  logic [CNT_W-1:0] sat_cnt_reg;

  // The top two bits disagree exactly when the value does not fit in WIDTH bits.
  always_comb begin
    ovf         = data_in[WIDTH] ^ data_in[WIDTH-1];
    pos_next    = ovf & ~data_in[WIDTH];
    neg_next    = ovf & data_in[WIDTH];
    result_next = data_in[WIDTH-1:0];
    if (pos_next) begin
      result_next = MAX_VAL;
    end else if (neg_next) begin
      result_next = MIN_VAL;
    end
  end

  assign cnt_full = &sat_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      data_out_reg   <= '0;
      sat_pos_reg    <= 1'b0;
      sat_neg_reg    <= 1'b0;
      sat_sticky_reg <= 1'b0;
      sat_cnt_reg    <= '0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        data_out_reg <= result_next;
        sat_pos_reg  <= pos_next;
        sat_neg_reg  <= neg_next;
      end else begin
        sat_pos_reg  <= 1'b0;
        sat_neg_reg  <= 1'b0;
      end
      // Clear wins over a coincident saturation, which is then not counted.
      if (cnt_clr) begin
        sat_cnt_reg    <= '0;
        sat_sticky_reg <= 1'b0;
      end else if (in_valid && ovf) begin
        sat_sticky_reg <= 1'b1;
        if (!cnt_full) begin
          sat_cnt_reg <= sat_cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign data_out   = data_out_reg;
  assign sat_pos    = sat_pos_reg;
  assign sat_neg    = sat_neg_reg;
  assign sat_sticky = sat_sticky_reg;
  assign sat_cnt    = sat_cnt_reg;

endmodule

// File: tb/tb_bit_slice_saturate.sv
// Self-checking bench for bit_slice_saturate: directed boundary steps followed by random
// samples, all checked against an integer-arithmetic clamp/count model.
module tb_bit_slice_saturate;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;
  localparam int MAXV  = 32767;
  localparam int MINV  = -32768;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH:0]   data_in;
  logic             cnt_clr;
  logic             out_valid;
  logic [WIDTH-1:0] data_out;
  logic             sat_pos;
  logic             sat_neg;
  logic             sat_sticky;
  logic [CNT_W-1:0] sat_cnt;

  logic             out_valid2;
  logic [WIDTH-1:0] data_out2;
  logic             sat_pos2;
  logic             sat_neg2;
  logic             sat_sticky2;
  logic [1:0]       sat_cnt2;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int exp_valid, exp_data, exp_pos, exp_neg, exp_sticky, exp_cnt, exp_cnt2;

  bit_slice_saturate #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .data_out(data_out), .sat_pos(sat_pos), .sat_neg(sat_neg),
    .sat_sticky(sat_sticky), .sat_cnt(sat_cnt)
  );

  bit_slice_saturate #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in), .cnt_clr(cnt_clr),
    .out_valid(out_valid2), .data_out(data_out2), .sat_pos(sat_pos2), .sat_neg(sat_neg2),
    .sat_sticky(sat_sticky2), .sat_cnt(sat_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_valid = 0; exp_data = 0; exp_pos = 0; exp_neg = 0;
    exp_sticky = 0; exp_cnt = 0; exp_cnt2 = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_word;
    exp_word = exp_data;
    check({tag, ".out_valid"}, {31'd0, out_valid}, exp_valid);
    check({tag, ".data_out"}, {16'd0, data_out}, {16'd0, exp_word[15:0]});
    check({tag, ".sat_pos"}, {31'd0, sat_pos}, exp_pos);
    check({tag, ".sat_neg"}, {31'd0, sat_neg}, exp_neg);
    check({tag, ".sat_sticky"}, {31'd0, sat_sticky}, exp_sticky);
    check({tag, ".sat_cnt"}, {16'd0, sat_cnt}, exp_cnt);
    check({tag, ".sat_cnt2"}, {30'd0, sat_cnt2}, exp_cnt2);
  endtask

  // Apply one cycle of input, then check the registered result 1 ns after the edge.
  task automatic step(input string tag, input bit v, input int val, input bit clr);
    logic [31:0] val_bits;
    bit sat;
    val_bits = val;
    in_valid = v;
    data_in  = val_bits[WIDTH:0];
    cnt_clr  = clr;
    @(posedge clk);
    #1;
    sat = (val > MAXV) || (val < MINV);
    exp_valid = v;
    if (v) begin
      exp_data = (val > MAXV) ? MAXV : (val < MINV) ? MINV : val;
      exp_pos  = (val > MAXV);
      exp_neg  = (val < MINV);
    end else begin
      exp_pos = 0;
      exp_neg = 0;
    end
    if (clr) begin
      exp_cnt = 0; exp_cnt2 = 0; exp_sticky = 0;
    end else if (v && sat) begin
      exp_sticky = 1;
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    $display("step %-10s v=%0d in=%0d clr=%0d -> out_valid=%0d data_out=0x%04h pos=%0d neg=%0d sticky=%0d cnt=%0d cnt2=%0d",
             tag, v, val, clr, out_valid, data_out, sat_pos, sat_neg, sat_sticky, sat_cnt, sat_cnt2);
    check_all(tag);
  endtask

  function automatic int rand_sample();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0: return int'($urandom_range(0, 131071)) - 65536;
      1: return MAXV - 3 + int'($urandom_range(0, 6));
      2: return MINV - 3 + int'($urandom_range(0, 6));
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0; in_valid = 1'b1; data_in = 17'd34468; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("first", 1, 5, 0);
    // In-range back-to-back
    step("inr_a", 1, -3168, 0);
    check("inr_a.hex", {16'd0, data_out}, 32'h0000_F3A0);
    step("inr_b", 1, -1, 0);
    step("inr_c", 1, -2, 0);
    step("inr_d", 1, 2, 0);
    step("inr_e", 1, 3, 0);
    // Positive clamp and boundaries
    step("pos_big", 1, 34468, 0);
    check("pos_big.hex", {16'd0, data_out}, 32'h0000_7FFF);
    step("pos_max", 1, 32767, 0);
    step("pos_over", 1, 32768, 0);
    step("pos_ext", 1, 65535, 0);
    // Negative clamp and boundaries
    step("neg_big", 1, -34468, 0);
    check("neg_big.hex", {16'd0, data_out}, 32'h0000_8000);
    step("neg_min", 1, -32768, 0);
    step("neg_over", 1, -32769, 0);
    step("neg_ext", 1, -65536, 0);
    // Valid gating: saturating value on an idle cycle changes nothing
    step("gate", 0, 34468, 0);
    step("gate2", 0, -100, 0);
    // Counter: clear, three events, clear coincident with a fourth, then five events
    step("clr0", 0, 0, 1);
    step("cnt1", 1, 40000, 0);
    step("cnt2", 1, -40000, 0);
    step("cnt3", 1, 32768, 0);
    step("clr_sat", 1, 40000, 1);
    for (int i = 0; i < 5; i++) step("cnt_sat", 1, -50000, 0);
    check("cnt2_hold", {30'd0, sat_cnt2}, 32'd3);

    // Mid-stream asynchronous reset discards the in-flight sample
    @(negedge clk);
    in_valid = 1'b1; data_in = 17'd40000;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 9) < 8), rand_sample(), ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
